oam_bus_arbiter: RTL and testbench

Bus responder and arbiter between the CPU, the OAM DMA engine, the external memory bus, OAM and the IO/HRAM region. It services the DMA engine's read/write strobes with the exact data-return timing that engine expects. While DMA owns the bus, it blocks CPU memory accesses, except to FF00–FFFF. It decodes addresses onto the external bus, the OAM port and the IO port with registered request outputs.

---
 rtl/oam_bus_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_oam_bus_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/oam_bus_arbiter.sv
// ============================================================================
//  Module      : oam_bus_arbiter
//  Description : Bus responder and arbiter that connects the CPU and the OAM
//                DMA engine to the external bus, OAM and the IO/HRAM region.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module oam_bus_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  ct,
  input  logic [15:0] cpu_a,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  input  logic [15:0] dma_a,
  input  logic        dma_rd,
  input  logic        dma_wr,
  input  logic [7:0]  dma_dout,
  output logic [7:0]  dma_din,
  input  logic        dma_occupy_bus,
  output logic [15:0] ext_a,
  output logic        ext_rd,
  output logic        ext_wr,
  output logic [7:0]  ext_wdata,
  input  logic [7:0]  ext_rdata,
  output logic [7:0]  oam_a,
  output logic        oam_we,
  output logic [7:0]  oam_wdata,
  input  logic [7:0]  oam_rdata,
  output logic [7:0]  io_a,
  output logic        io_rd,
  output logic        io_wr,
  output logic [7:0]  io_wdata,
  input  logic [7:0]  io_rdata
);

  localparam logic [1:0] RT_EXT = 2'd0;
  localparam logic [1:0] RT_OAM = 2'd1;
  localparam logic [1:0] RT_IO  = 2'd2;
  localparam logic [1:0] RT_FF  = 2'd3;

  typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_t;

  owner_t      owner_q, owner_d;
  logic [1:0]  cpu_route_q, cpu_route_d, dma_route_q, dma_route_d;
  logic [15:0] ext_a_q, ext_a_d;
  logic        ext_rd_q, ext_rd_d, ext_wr_q, ext_wr_d;
  logic [7:0]  ext_wdata_q, ext_wdata_d;
  logic [7:0]  oam_a_q, oam_a_d, oam_wdata_q, oam_wdata_d;
  logic        oam_we_q, oam_we_d;
  logic [7:0]  io_a_q, io_a_d, io_wdata_q, io_wdata_d;
  logic        io_rd_q, io_rd_d, io_wr_q, io_wr_d;

  logic        dma_act, cpu_ok, dma_ext, dma_oam, dma_io;
  logic [1:0]  cpu_tgt, dma_tgt;

  function automatic logic [1:0] decode(input logic [15:0] a);
    if (a[15:8] == 8'hFF)      decode = RT_IO;
    else if (a[15:8] == 8'hFE) decode = (a[7:0] < 8'hA0) ? RT_OAM : RT_FF;
    else                       decode = RT_EXT;
  endfunction

  always_comb begin
    dma_act     = dma_rd | dma_wr | dma_occupy_bus;
    cpu_tgt     = decode(cpu_a);
    dma_tgt     = decode(dma_a);
    cpu_ok      = !(owner_q == OWN_DMA || dma_act) || (cpu_tgt == RT_IO);
    dma_ext     = 1'b0;
    dma_oam     = 1'b0;
    dma_io      = 1'b0;
    owner_d     = owner_q;
    cpu_route_d = cpu_route_q;
    dma_route_d = dma_route_q;
    ext_a_d     = ext_a_q;
    ext_wdata_d = ext_wdata_q;
    ext_rd_d    = 1'b0;
    ext_wr_d    = 1'b0;
    oam_a_d     = oam_a_q;
    oam_wdata_d = oam_wdata_q;
    oam_we_d    = 1'b0;
    io_a_d      = io_a_q;
    io_wdata_d  = io_wdata_q;
    io_rd_d     = 1'b0;
    io_wr_d     = 1'b0;

    if (dma_act)
      owner_d = OWN_DMA;
    else if (owner_q == OWN_DMA && ct == 2'd3)
      owner_d = OWN_CPU;

    // DMA is served first so it wins any port the CPU also wants.
    if (dma_wr) begin
      case (dma_tgt)
        RT_EXT: begin ext_wr_d = 1'b1; ext_a_d = dma_a; ext_wdata_d = dma_dout; dma_ext = 1'b1; end
        RT_OAM: begin oam_we_d = 1'b1; oam_a_d = dma_a[7:0]; oam_wdata_d = dma_dout; dma_oam = 1'b1; end
        RT_IO:  begin io_wr_d = 1'b1; io_a_d = dma_a[7:0]; io_wdata_d = dma_dout; dma_io = 1'b1; end
        default: ;
      endcase
    end else if (dma_rd) begin
      if (dma_a[15:9] == 7'h7F) begin
        dma_route_d = RT_FF;
      end else begin
        ext_rd_d    = 1'b1;
        ext_a_d     = dma_a;
        dma_ext     = 1'b1;
        dma_route_d = RT_EXT;
      end
    end

    if (cpu_wr) begin
      if (cpu_ok) begin
        case (cpu_tgt)
          RT_EXT: if (!dma_ext) begin ext_wr_d = 1'b1; ext_a_d = cpu_a; ext_wdata_d = cpu_dout; end
          RT_OAM: if (!dma_oam) begin oam_we_d = 1'b1; oam_a_d = cpu_a[7:0]; oam_wdata_d = cpu_dout; end
          RT_IO:  if (!dma_io) begin io_wr_d = 1'b1; io_a_d = cpu_a[7:0]; io_wdata_d = cpu_dout; end
          default: ;
        endcase
      end
    end else if (cpu_rd) begin
      cpu_route_d = cpu_ok ? cpu_tgt : RT_FF;
      if (cpu_ok) begin
        case (cpu_tgt)
          RT_EXT: if (!dma_ext) begin ext_rd_d = 1'b1; ext_a_d = cpu_a; end
          RT_OAM: if (!dma_oam) oam_a_d = cpu_a[7:0];
          RT_IO:  if (!dma_io) begin io_rd_d = 1'b1; io_a_d = cpu_a[7:0]; end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q     <= OWN_CPU;
      cpu_route_q <= RT_FF;
      dma_route_q <= RT_FF;
      ext_a_q     <= 16'h0000;
      ext_rd_q    <= 1'b0;
      ext_wr_q    <= 1'b0;
      ext_wdata_q <= 8'h00;
      oam_a_q     <= 8'h00;
      oam_we_q    <= 1'b0;
      oam_wdata_q <= 8'h00;
      io_a_q      <= 8'h00;
      io_rd_q     <= 1'b0;
      io_wr_q     <= 1'b0;
      io_wdata_q  <= 8'h00;
    end else begin
      owner_q     <= owner_d;
      cpu_route_q <= cpu_route_d;
      dma_route_q <= dma_route_d;
      ext_a_q     <= ext_a_d;
      ext_rd_q    <= ext_rd_d;
      ext_wr_q    <= ext_wr_d;
      ext_wdata_q <= ext_wdata_d;
      oam_a_q     <= oam_a_d;
      oam_we_q    <= oam_we_d;
      oam_wdata_q <= oam_wdata_d;
      io_a_q      <= io_a_d;
      io_rd_q     <= io_rd_d;
      io_wr_q     <= io_wr_d;
      io_wdata_q  <= io_wdata_d;
    end
  end

  always_comb begin
    case (cpu_route_q)
      RT_EXT:  cpu_din = ext_rdata;
      RT_OAM:  cpu_din = oam_rdata;
      RT_IO:   cpu_din = io_rdata;
      default: cpu_din = 8'hFF;
    endcase
    case (dma_route_q)
      RT_EXT:  dma_din = ext_rdata;
      RT_OAM:  dma_din = oam_rdata;
      default: dma_din = 8'hFF;
    endcase
  end

  assign ext_a     = ext_a_q;
  assign ext_rd    = ext_rd_q;
  assign ext_wr    = ext_wr_q;
  assign ext_wdata = ext_wdata_q;
  assign oam_a     = oam_a_q;
  assign oam_we    = oam_we_q;
  assign oam_wdata = oam_wdata_q;
  assign io_a      = io_a_q;
  assign io_rd     = io_rd_q;
  assign io_wr     = io_wr_q;
  assign io_wdata  = io_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_oam_bus_arbiter.sv
// ============================================================================
//  Module      : tb_oam_bus_arbiter
//  Description : Scoreboard bench for oam_bus_arbiter with directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_oam_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  ct = 2'd0;
  logic [15:0] cpu_a = 16'h0000;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [7:0]  cpu_dout = 8'h00, cpu_din;
  logic [15:0] dma_a = 16'h0000;
  logic        dma_rd = 1'b0, dma_wr = 1'b0, dma_occupy_bus = 1'b0;
  logic [7:0]  dma_dout = 8'h00, dma_din;
  logic [15:0] ext_a;
  logic        ext_rd, ext_wr;
  logic [7:0]  ext_wdata, ext_rdata;
  logic [7:0]  oam_a, oam_wdata, oam_rdata;
  logic        oam_we;
  logic [7:0]  io_a, io_wdata, io_rdata;
  logic        io_rd, io_wr;

  always #5 clk = ~clk;

  // Memory models: ext returns its low address byte, IO a scrambled address.
  assign ext_rdata = ext_a[7:0];
  assign oam_rdata = oam_a ^ 8'h5A;
  assign io_rdata  = io_a ^ 8'h3C;

  oam_bus_arbiter dut (
    .clk(clk), .rst(rst), .ct(ct),
    .cpu_a(cpu_a), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
    .dma_a(dma_a), .dma_rd(dma_rd), .dma_wr(dma_wr), .dma_dout(dma_dout), .dma_din(dma_din),
    .dma_occupy_bus(dma_occupy_bus),
    .ext_a(ext_a), .ext_rd(ext_rd), .ext_wr(ext_wr), .ext_wdata(ext_wdata), .ext_rdata(ext_rdata),
    .oam_a(oam_a), .oam_we(oam_we), .oam_wdata(oam_wdata), .oam_rdata(oam_rdata),
    .io_a(io_a), .io_rd(io_rd), .io_wr(io_wr), .io_wdata(io_wdata), .io_rdata(io_rdata)
  );

  int checks = 0;
  int failures = 0;

  logic [15:0] ext_rd_q[$];
  logic [23:0] ext_wr_q[$];
  logic [15:0] oam_q[$];
  logic [7:0]  io_rd_q[$];
  logic [15:0] io_wr_q[$];
  logic [7:0]  cpu_q[$];
  logic [7:0]  dma_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got unexpected event %h expected none", name, act);
  endtask

  // Monitor: p_* are the inputs sampled at the most recent rising edge.
  logic p_cpu_rd = 1'b0, p_dma_rd = 1'b0, p2_dma_rd = 1'b0;

  always @(negedge clk) begin
    if (p_dma_rd && !p2_dma_rd) begin
      if (dma_q.size() == 0) unexpected("dma_din", {24'h0, dma_din});
      else chk("dma_din", {24'h0, dma_din}, {24'h0, dma_q.pop_front()});
    end
    if (p_cpu_rd) begin
      if (cpu_q.size() == 0) unexpected("cpu_din", {24'h0, cpu_din});
      else chk("cpu_din", {24'h0, cpu_din}, {24'h0, cpu_q.pop_front()});
    end
    if (ext_rd === 1'b1) begin
      if (ext_rd_q.size() == 0) unexpected("ext_rd", {16'h0, ext_a});
      else chk("ext_rd addr", {16'h0, ext_a}, {16'h0, ext_rd_q.pop_front()});
    end
    if (ext_wr === 1'b1) begin
      if (ext_wr_q.size() == 0) unexpected("ext_wr", {8'h0, ext_a, ext_wdata});
      else chk("ext_wr addr/data", {8'h0, ext_a, ext_wdata}, {8'h0, ext_wr_q.pop_front()});
    end
    if (oam_we === 1'b1) begin
      if (oam_q.size() == 0) unexpected("oam_we", {16'h0, oam_a, oam_wdata});
      else chk("oam_we addr/data", {16'h0, oam_a, oam_wdata}, {16'h0, oam_q.pop_front()});
    end
    if (io_rd === 1'b1) begin
      if (io_rd_q.size() == 0) unexpected("io_rd", {24'h0, io_a});
      else chk("io_rd addr", {24'h0, io_a}, {24'h0, io_rd_q.pop_front()});
    end
    if (io_wr === 1'b1) begin
      if (io_wr_q.size() == 0) unexpected("io_wr", {16'h0, io_a, io_wdata});
      else chk("io_wr addr/data", {16'h0, io_a, io_wdata}, {16'h0, io_wr_q.pop_front()});
    end
    p2_dma_rd = p_dma_rd;
    p_dma_rd  = dma_rd;
    p_cpu_rd  = cpu_rd;
  end

  task automatic step();
    @(posedge clk);
    #1;
    ct = ct + 2'd1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " ext_rd"}, {31'h0, ext_rd}, 32'h0);
    chk({tag, " ext_wr"}, {31'h0, ext_wr}, 32'h0);
    chk({tag, " oam_we"}, {31'h0, oam_we}, 32'h0);
    chk({tag, " io_rd"},  {31'h0, io_rd},  32'h0);
    chk({tag, " io_wr"},  {31'h0, io_wr},  32'h0);
    chk({tag, " cpu_din"}, {24'h0, cpu_din}, 32'hFF);
    chk({tag, " dma_din"}, {24'h0, dma_din}, 32'hFF);
  endtask

  logic [7:0] d;

  initial begin
    // Reset state
    repeat (3) step();
    chk_idle("reset");
    chk("reset ext_a", {16'h0, ext_a}, 32'h0000);
    chk("reset oam_a", {24'h0, oam_a}, 32'h00);
    chk("reset io_a",  {24'h0, io_a},  32'h00);
    chk("reset ext_wdata", {24'h0, ext_wdata}, 32'h00);
    chk("reset oam_wdata", {24'h0, oam_wdata}, 32'h00);
    chk("reset io_wdata",  {24'h0, io_wdata},  32'h00);
    rst = 1'b0;

    // CPU alone: ext read, void write/read, IO write, OAM write
    step(); cpu_rd = 1'b1; cpu_a = 16'hC042;
    ext_rd_q.push_back(16'hC042); cpu_q.push_back(8'h42);
    step(); cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_a = 16'hFEA5; cpu_dout = 8'h99;
    step(); cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_a = 16'hFEA5; cpu_q.push_back(8'hFF);
    step(); cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_a = 16'hFF10; cpu_dout = 8'h77;
    io_wr_q.push_back({8'h10, 8'h77});
    step(); cpu_a = 16'hFE20; cpu_dout = 8'h33; oam_q.push_back({8'h20, 8'h33});
    step(); cpu_wr = 1'b0;

    // DMA owns the bus: CPU ext/OAM-space accesses are blocked
    step(); dma_occupy_bus = 1'b1; cpu_wr = 1'b1; cpu_a = 16'hC123; cpu_dout = 8'h55;
    step(); cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_a = 16'h8000; cpu_q.push_back(8'hFF);
    step(); cpu_rd = 1'b0;

    // Full 160-byte OAM DMA from C000
    for (int i = 0; i < 160; i++) begin
      step(); dma_rd = 1'b1; dma_a = 16'(16'hC000 + i);
      ext_rd_q.push_back(16'(16'hC000 + i));
      ext_rd_q.push_back(16'(16'hC000 + i));
      dma_q.push_back(8'(i));
      if (i == 5) begin
        cpu_rd = 1'b1; cpu_a = 16'hFF85;
        io_rd_q.push_back(8'h85); cpu_q.push_back(8'hB9);
      end
      if (i == 6) begin
        cpu_rd = 1'b1; cpu_a = 16'h8000; cpu_q.push_back(8'hFF);
      end
      step(); cpu_rd = 1'b0;
      @(negedge clk); d = dma_din;
      step(); dma_rd = 1'b0; dma_wr = 1'b1; dma_a = 16'(16'hFE00 + i); dma_dout = d;
      oam_q.push_back({8'(i), 8'(i)});
      step(); dma_wr = 1'b0;
    end

    // Release the bus when ct=1; ownership returns only at ct==3
    while (ct != 2'd1) step();
    dma_occupy_bus = 1'b0;
    step(); cpu_rd = 1'b1; cpu_a = 16'hC000; cpu_q.push_back(8'hFF);
    step(); cpu_rd = 1'b0;
    step(); cpu_rd = 1'b1; cpu_a = 16'hC000;
    ext_rd_q.push_back(16'hC000); cpu_q.push_back(8'h00);
    step(); cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_a = 16'hC123; cpu_dout = 8'h55;
    ext_wr_q.push_back({16'hC123, 8'h55});
    step(); cpu_wr = 1'b0;

    // Reset while an OAM write is in progress
    step(); dma_wr = 1'b1; dma_a = 16'hFE10; dma_dout = 8'hAA; oam_q.push_back({8'h10, 8'hAA});
    step(); rst = 1'b1;
    step(); chk_idle("mid-reset");
    rst = 1'b0; dma_wr = 1'b0; cpu_rd = 1'b1; cpu_a = 16'hC000;
    ext_rd_q.push_back(16'hC000); cpu_q.push_back(8'h00);
    step(); cpu_rd = 1'b0;
    repeat (3) step();

    chk("pending ext_rd", ext_rd_q.size(), 0);
    chk("pending ext_wr", ext_wr_q.size(), 0);
    chk("pending oam_we", oam_q.size(), 0);
    chk("pending io_rd",  io_rd_q.size(), 0);
    chk("pending io_wr",  io_wr_q.size(), 0);
    chk("pending cpu_din", cpu_q.size(), 0);
    chk("pending dma_din", dma_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
